// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU slice:
//   - internal ALU op codes carried on op_code
//   - main-control ALUOp encodings and the R-type funct values that decode
//   - controller state enum
// ---------------------------------------------------------------------------
package alu_pkg;

  // Internal ALU operations
  localparam logic [5:0] ALU_NOP = 6'b000000;
  localparam logic [5:0] ALU_ADD = 6'b001001;
  localparam logic [5:0] ALU_SUB = 6'b001010;
  localparam logic [5:0] ALU_OR  = 6'b010010;
  localparam logic [5:0] ALU_SRL = 6'b100010;
  localparam logic [5:0] ALU_MUL = 6'b000011;

  // Main-control ALUOp classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // R-type funct values recognised when ALUOp selects R-type
  localparam logic [5:0] FUNCT_ADD = 6'b001011;
  localparam logic [5:0] FUNCT_SUB = 6'b001101;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_MUL = 6'b011001;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ---------------------------------------------------------------------------
// alu_ctrl_dec
// Purely combinational ALU control decoder. Maps the main-control ALUOp
// class and the instruction funct field onto an internal ALU op.
// Anything that does not map (reserved ALUOp, unknown funct, or multiply
// in a build without the multiplier) becomes ALU_NOP with illegal set.
//
// Ports:
//   ALUOp      in   2  main-control op class
//   funct_ctrl in   6  funct field, only looked at for R-type
//   op         out  6  decoded internal ALU op
//   illegal    out  1  request decodes to no operation
// ---------------------------------------------------------------------------
module alu_ctrl_dec
  import alu_pkg::*;
#(
  parameter int MUL_EN = 1
) (
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct_ctrl,
  output logic [5:0] op,
  output logic       illegal
);

  // Decode table; every path not listed falls through to ALU_NOP.
  always_comb begin
    op = ALU_NOP;
    case (ALUOp)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct_ctrl)
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_SRL: op = ALU_SRL;
          FUNCT_MUL: begin
            if (MUL_EN != 0) begin
              op = ALU_MUL;
            end
          end
          default: op = ALU_NOP;
        endcase
      end
      default: op = ALU_NOP;
    endcase
  end

  assign illegal = (op == ALU_NOP);

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with a valid/ready request side and a one-cycle result
// pulse. ADD/SUB/OR/SRL and illegal requests complete one cycle after
// accept; MUL runs an unsigned shift-add over DATA_W cycles and completes
// DATA_W+1 cycles after accept. Only one request is in flight at a time.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  request handshake (ready only while idle)
//   ALUOp, funct_ctrl  control fields fed to alu_ctrl_dec
//   src_a, src_b       DATA_W-bit operands
//   shamt              logical right-shift amount for SRL
//   out_valid          one-cycle completion pulse
//   result, result_hi  low / high result halves (high is 0 except MUL)
//   zero               whole result is zero
//   illegal            completed request decoded to no operation
//   op_code            internal op of the completed request
// ---------------------------------------------------------------------------
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MUL_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                ALUOp,
  input  logic [5:0]                funct_ctrl,
  input  logic [DATA_W-1:0]         src_a,
  input  logic [DATA_W-1:0]         src_b,
  input  logic [$clog2(DATA_W)-1:0] shamt,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         result,
  output logic [DATA_W-1:0]         result_hi,
  output logic                      zero,
  output logic                      illegal,
  output logic [5:0]                op_code
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  state_t state_q;
  state_t state_d;

  logic [5:0] dec_op;
  logic       dec_illegal;
  logic       accept;

  logic [DATA_W-1:0]   single_res;

  logic [2*DATA_W-1:0] mul_mcand_q;
  logic [DATA_W-1:0]   mul_mplier_q;
  logic [2*DATA_W-1:0] mul_acc_q;
  logic [2*DATA_W-1:0] mul_acc_next;
  logic [CNT_W-1:0]    mul_cnt_q;
  logic                mul_last;

  logic illegal_q;

  alu_ctrl_dec #(
    .MUL_EN (MUL_EN)
  ) u_dec (
    .ALUOp      (ALUOp),
    .funct_ctrl (funct_ctrl),
    .op         (dec_op),
    .illegal    (dec_illegal)
  );

  assign accept   = in_valid && in_ready;
  assign mul_last = (state_q == MUL) && (mul_cnt_q == LAST_ITER);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs. Requests arriving while busy are
  // simply not acknowledged; nothing is queued.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (dec_op == ALU_MUL) ? MUL : DONE;
        end
      end
      MUL: begin
        if (mul_cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle results straight from the live operands; illegal gives 0.
  always_comb begin
    single_res = '0;
    case (dec_op)
      ALU_ADD: single_res = src_a + src_b;
      ALU_SUB: single_res = src_a - src_b;
      ALU_OR:  single_res = src_a | src_b;
      ALU_SRL: single_res = src_a >> shamt;
      default: single_res = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign mul_acc_next = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);

  // Multiplier working registers. Operands are captured at accept so the
  // requester is free to change its inputs during the iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_acc_q    <= '0;
      mul_cnt_q    <= '0;
    end else if (accept && (dec_op == ALU_MUL)) begin
      mul_mcand_q  <= {{DATA_W{1'b0}}, src_a};
      mul_mplier_q <= src_b;
      mul_acc_q    <= '0;
      mul_cnt_q    <= '0;
    end else if (state_q == MUL) begin
      mul_mcand_q  <= mul_mcand_q << 1;
      mul_mplier_q <= mul_mplier_q >> 1;
      mul_acc_q    <= mul_acc_next;
      mul_cnt_q    <= mul_cnt_q + CNT_W'(1);
    end
  end

  // Result registers only change on the edge that enters DONE, so they
  // keep showing the previous completion while a multiply is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      illegal_q <= 1'b0;
      op_code   <= ALU_NOP;
    end else if (accept && (dec_op != ALU_MUL)) begin
      result    <= single_res;
      result_hi <= '0;
      zero      <= (single_res == '0);
      illegal_q <= dec_illegal;
      op_code   <= dec_op;
    end else if (mul_last) begin
      result    <= mul_acc_next[DATA_W-1:0];
      result_hi <= mul_acc_next[2*DATA_W-1:DATA_W];
      zero      <= (mul_acc_next == '0);
      illegal_q <= 1'b0;
      op_code   <= ALU_MUL;
    end
  end

  // illegal is only meaningful during the completion pulse, so it is
  // qualified by out_valid rather than left standing between requests.
  assign illegal = illegal_q && out_valid;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc
// Self-checking bench for alu_mc. A driver issues requests and pushes the
// reference-model response into a scoreboard queue; a monitor on the
// falling edge pops and compares whenever out_valid is seen, and also
// tracks in_ready, output hold behaviour and reset values. Two small
// DATA_W=8 instances (with and without the multiplier) cover the narrow
// width and the multiplier-less build.
// ---------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ill;
    logic [5:0]   op;
    int           lat;
    int           due;
  } exp_t;

  // Main DUT signals
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   ALUOp = 2'b00;
  logic [5:0]   funct_ctrl = 6'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [4:0]   shamt = '0;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         illegal;
  logic [5:0]   op_code;

  // Shared inputs for the two 8-bit DUTs
  logic       s_valid = 1'b0;
  logic [1:0] s_aluop = 2'b00;
  logic [5:0] s_funct = 6'b0;
  logic [7:0] s_a = '0;
  logic [7:0] s_b = '0;
  logic [2:0] s_shamt = '0;

  logic       r8_ready, r8_valid, r8_zero, r8_ill;
  logic [7:0] r8_res, r8_hi;
  logic [5:0] r8_op;
  logic       nm_ready, nm_valid, nm_zero, nm_ill;
  logic [7:0] nm_res, nm_hi;
  logic [5:0] nm_op;

  // Bookkeeping
  exp_t         sb_q[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           free_cyc = 0;
  bit           rst_at_edge = 1'b0;
  bit           started = 1'b0;
  logic [W-1:0] last_res;
  logic [W-1:0] last_hi;
  logic         last_zero;
  logic [5:0]   last_op;

  always #5 clk = ~clk;

  alu_mc #(.DATA_W(W), .MUL_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUOp      (ALUOp),
    .funct_ctrl (funct_ctrl),
    .src_a      (src_a),
    .src_b      (src_b),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .result     (result),
    .result_hi  (result_hi),
    .zero       (zero),
    .illegal    (illegal),
    .op_code    (op_code)
  );

  alu_mc #(.DATA_W(8), .MUL_EN(1)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_valid),
    .in_ready   (r8_ready),
    .ALUOp      (s_aluop),
    .funct_ctrl (s_funct),
    .src_a      (s_a),
    .src_b      (s_b),
    .shamt      (s_shamt),
    .out_valid  (r8_valid),
    .result     (r8_res),
    .result_hi  (r8_hi),
    .zero       (r8_zero),
    .illegal    (r8_ill),
    .op_code    (r8_op)
  );

  alu_mc #(.DATA_W(8), .MUL_EN(0)) dut_nm (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_valid),
    .in_ready   (nm_ready),
    .ALUOp      (s_aluop),
    .funct_ctrl (s_funct),
    .src_a      (s_a),
    .src_b      (s_b),
    .shamt      (s_shamt),
    .out_valid  (nm_valid),
    .result     (nm_res),
    .result_hi  (nm_hi),
    .zero       (nm_zero),
    .illegal    (nm_ill),
    .op_code    (nm_op)
  );

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string name, input logic [79:0] act,
                             input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: straight arithmetic from the op table.
  function automatic exp_t model(input logic [1:0] aop, input logic [5:0] f,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [4:0] sh);
    exp_t         e;
    logic [63:0]  prod;
    bit           bad;
    e.res = '0;
    e.hi  = '0;
    e.ill = 1'b0;
    e.op  = 6'b000000;
    e.lat = 1;
    e.due = 0;
    bad   = 1'b0;
    if (aop == 2'b00) begin
      e.res = x + y; e.op = 6'b001001;
    end else if (aop == 2'b01) begin
      e.res = x - y; e.op = 6'b001010;
    end else if (aop == 2'b10) begin
      if (f == 6'b001011) begin
        e.res = x + y; e.op = 6'b001001;
      end else if (f == 6'b001101) begin
        e.res = x - y; e.op = 6'b001010;
      end else if (f == 6'b100101) begin
        e.res = x | y; e.op = 6'b010010;
      end else if (f == 6'b000010) begin
        e.res = x >> sh; e.op = 6'b100010;
      end else if (f == 6'b011001) begin
        prod  = {32'b0, x} * {32'b0, y};
        e.res = prod[31:0];
        e.hi  = prod[63:32];
        e.op  = 6'b000011;
        e.lat = W + 1;
      end else begin
        bad = 1'b1;
      end
    end else begin
      bad = 1'b1;
    end
    if (bad) begin
      e.ill = 1'b1;
      e.res = '0;
      e.hi  = '0;
      e.op  = 6'b000000;
    end
    e.zero = (e.res == '0) && (e.hi == '0);
    return e;
  endfunction

  // Edge bookkeeping for the monitor.
  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_at_edge = rst;
    if (rst) started = 1'b1;
  end

  // Monitor: reset values, in_ready against the model's busy window,
  // scoreboard compare on out_valid, and output hold between pulses.
  always @(negedge clk) begin
    if (started) begin
      if (rst_at_edge) begin
        checkOutput("reset_in_ready", 80'(in_ready), 80'(1));
        checkOutput("reset_out_valid", 80'(out_valid), 80'(0));
        checkOutput("reset_result", 80'({result_hi, result}), 80'(0));
        checkOutput("reset_flags", 80'({zero, illegal, op_code}), 80'({1'b1, 1'b0, 6'b0}));
        last_res  = '0;
        last_hi   = '0;
        last_zero = 1'b1;
        last_op   = 6'b0;
      end else begin
        checkOutput("in_ready", 80'(in_ready), 80'(cyc >= free_cyc));
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_out_valid: got out_valid=1 expected no response (cycle %0d)", cyc);
          end else begin
            mon_e = sb_q.pop_front();
            checkOutput("latency", 80'(cyc), 80'(mon_e.due));
            checkOutput("result", 80'(result), 80'(mon_e.res));
            checkOutput("result_hi", 80'(result_hi), 80'(mon_e.hi));
            checkOutput("zero", 80'(zero), 80'(mon_e.zero));
            checkOutput("illegal", 80'(illegal), 80'(mon_e.ill));
            checkOutput("op_code", 80'(op_code), 80'(mon_e.op));
            last_res  = mon_e.res;
            last_hi   = mon_e.hi;
            last_zero = mon_e.zero;
            last_op   = mon_e.op;
          end
        end else begin
          checkOutput("idle_illegal", 80'(illegal), 80'(0));
          checkOutput("hold", 80'({result_hi, result, zero, op_code}),
                      80'({last_hi, last_res, last_zero, last_op}));
        end
      end
    end
  end

  // Issue one request and wait (bounded) for it to be taken. Called and
  // returns just after a rising edge. in_valid is dropped and possibly
  // re-raised by the next call in the same timestep, so back-to-back calls
  // look like in_valid held high to the DUT.
  task automatic applyStimulus(input logic [1:0] aop, input logic [5:0] f,
                               input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [4:0] sh);
    exp_t e;
    int   acc;
    bit   got;
    e   = model(aop, f, x, y, sh);
    acc = 0;
    got = 1'b0;
    ALUOp      = aop;
    funct_ctrl = f;
    src_a      = x;
    src_b      = y;
    shamt      = sh;
    in_valid   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles expected accept");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.due = acc + e.lat;
    sb_q.push_back(e);
    free_cyc = acc + e.lat + 1;
    in_valid = 1'b0;
  endtask

  // Start a multiply and reset it in its tenth busy cycle; no response
  // may ever appear for it.
  task automatic abortMul();
    bit got;
    got = 1'b0;
    ALUOp      = 2'b10;
    funct_ctrl = 6'b011001;
    src_a      = $urandom;
    src_b      = $urandom;
    in_valid   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL abort_accept_timeout: got in_ready=0 expected accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    free_cyc = cyc + 1000;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    free_cyc = cyc;
    repeat (W + 5) @(posedge clk);
    #1;
  endtask

  // Narrow-width and multiplier-less builds.
  task automatic smallTests();
    int seen;
    seen    = 0;
    s_aluop = 2'b10;
    s_funct = 6'b000010;
    s_a     = 8'h80;
    s_b     = 8'h00;
    s_shamt = 3'd7;
    s_valid = 1'b1;
    @(negedge clk);
    checkOutput("w8_ready", 80'({r8_ready, nm_ready}), 80'(2'b11));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("w8_srl", 80'({r8_valid, r8_res}), 80'({1'b1, 8'h01}));
    checkOutput("nm_srl", 80'({nm_valid, nm_res}), 80'({1'b1, 8'h01}));
    @(posedge clk);
    #1;
    s_funct = 6'b011001;
    s_a     = 8'hFF;
    s_b     = 8'hFF;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("nm_mul_illegal", 80'({nm_valid, nm_ill, nm_res, nm_hi, nm_zero, nm_op}),
                    80'({1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 6'b0}));
      end
      if (r8_valid === 1'b1) begin
        seen = k;
        break;
      end
    end
    checkOutput("w8_mul_latency", 80'(seen), 80'(9));
    checkOutput("w8_mul_result", 80'({r8_hi, r8_res, r8_zero, r8_ill, r8_op}),
                80'({8'hFE, 8'h01, 1'b0, 1'b0, 6'b000011}));
    @(posedge clk);
    #1;
  endtask

  // Main sequence: reset, directed cases, abort, random traffic, small builds.
  initial begin
    logic [1:0]   aop;
    logic [5:0]   f;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   functs[7];
    int           gap;

    functs[0] = 6'b001011;
    functs[1] = 6'b001101;
    functs[2] = 6'b100101;
    functs[3] = 6'b000010;
    functs[4] = 6'b011001;
    functs[5] = 6'b000000;
    functs[6] = 6'b111111;

    $display("[TB] start");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    free_cyc = cyc;

    applyStimulus(2'b00, 6'b000000, 32'd5, 32'd7, 5'd0);
    applyStimulus(2'b10, 6'b001101, 32'd3, 32'd3, 5'd0);
    applyStimulus(2'b10, 6'b001101, 32'd0, 32'd1, 5'd0);
    applyStimulus(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2, 5'd0);
    applyStimulus(2'b00, 6'b000000, 32'd100, 32'd23, 5'd0);
    applyStimulus(2'b11, 6'b001011, 32'd9, 32'd9, 5'd0);
    applyStimulus(2'b10, 6'b000000, 32'd9, 32'd9, 5'd0);
    applyStimulus(2'b10, 6'b100101, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
    applyStimulus(2'b10, 6'b000010, 32'h8000_0000, 32'd0, 5'd31);
    applyStimulus(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 5'd0);
    applyStimulus(2'b01, 6'b000000, 32'd10, 32'd4, 5'd0);
    applyStimulus(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);

    abortMul();

    for (int n = 0; n < 40; n++) begin
      aop = 2'($urandom_range(0, 3));
      f   = functs[$urandom_range(0, 6)];
      x   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      y   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      applyStimulus(aop, f, x, y, 5'($urandom_range(0, 31)));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    smallTests();

    for (int k = 0; k < 100; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("scoreboard_drained", 80'(sb_q.size()), 80'(0));
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning operand/result width in bits (legal 8..64, power of 2).
REQ-002 SHALL provide parameter MUL_EN, default 1, meaning the multi-cycle multiply op is present (0: multiply decodes as illegal).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  request present this cycle.
REQ-006 SHALL provide port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL provide port ALUOp  input  2  main-control op class: 00 add, 01 sub, 10 R-type, 11 reserved.
REQ-008 SHALL provide port funct_ctrl  input  6  instruction funct field, used only when ALUOp=10.
REQ-009 SHALL provide ports src_a, src_b  input  DATA_W  operands; shamt  input  log2(DATA_W)  shift amount.
REQ-010 SHALL provide port out_valid  output  1  one-cycle pulse, result fields valid.
REQ-011 SHALL provide ports result  output  DATA_W  low result; result_hi  output  DATA_W  multiply high half (0 for other ops).
REQ-012 SHALL provide ports zero  output  1  (result==0 and result_hi==0); illegal  output  1  request decoded to no op.
REQ-013 SHALL provide port op_code  output  6  registered internal ALU op of the completed request.

Function
REQ-014 Decode SHALL be: ALUOp 00 -> ADD 001001; 01 -> SUB 001010; 10 with funct 001011 -> ADD, 001101 -> SUB, 100101 -> OR 010010, 000010 -> SRL 100010, 011001 -> MUL 000011 (if MUL_EN).
REQ-015 Any other funct with ALUOp=10, ALUOp=11, or MUL with MUL_EN=0 SHALL decode to op 000000 and complete as illegal.
REQ-016 Accept occurs when in_valid && in_ready; inputs are captured at that edge and need not be held afterward.
REQ-017 FSM states SHALL be IDLE, MUL, DONE; in_ready=1 only in IDLE.
REQ-018 IDLE, accepted single-cycle op (ADD/SUB/OR/SRL/illegal) -> DONE; result registered; out_valid asserts the next cycle (latency 1).
REQ-019 IDLE, accepted MUL -> MUL; unsigned shift-add, one multiplier bit per cycle, DATA_W cycles; -> DONE; out_valid at accept+DATA_W+1.
REQ-020 DONE SHALL last exactly one cycle with out_valid=1, then -> IDLE; no output backpressure.
REQ-021 ADD/SUB SHALL wrap modulo 2^DATA_W, no carry/overflow output; SRL is logical, by shamt; OR bitwise.
REQ-022 MUL SHALL produce full 2*DATA_W unsigned product: result=low half, result_hi=high half.
REQ-023 illegal SHALL be 1 only alongside out_valid for an illegal request; result/result_hi=0, zero=1 in that case.
REQ-024 result, result_hi, zero, op_code, illegal SHALL hold their last values while out_valid=0.
REQ-025 in_valid while in_ready=0 SHALL be ignored (no queueing); requester must retry.

Reset
REQ-026 rst SHALL force state IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, zero=1, illegal=0, op_code=000000.
REQ-027 rst asserted mid-MUL SHALL abort the operation with no out_valid pulse; rst has priority over accept on the same edge.

Structure
REQ-028 Package alu_pkg SHALL hold op-code constants (ALU_ADD, ALU_SUB, ALU_OR, ALU_SRL, ALU_MUL, ALU_NOP), ALUOp encodings and the FSM state enum.
REQ-029 Decode SHALL live in combinational sub-module alu_ctrl_dec (ALUOp, funct_ctrl, MUL_EN -> op, illegal); datapath and FSM in alu_mc.
REQ-030 Multiplier iteration counter SHALL be log2(DATA_W)+1 bits wide.

Verification
REQ-031 Reset then ALUOp=00, a=5, b=7 -> out_valid next cycle, result=12, zero=0, op_code=001001.
REQ-032 ALUOp=10 funct=001101, a=3, b=3 -> result=0, zero=1; a=0, b=1 -> result=FFFFFFFF (DATA_W=32).
REQ-033 ALUOp=10 funct=011001, a=FFFFFFFF, b=2 -> in_ready low 33 cycles, out_valid at accept+33, result=FFFFFFFE, result_hi=1.
REQ-034 ALUOp=11 and ALUOp=10 funct=000000 -> out_valid with illegal=1, result=0; MUL_EN=0 build: MUL -> illegal=1.
REQ-035 in_valid held high during MUL with a second ADD request -> ignored until in_ready returns; rst at MUL cycle 10 -> no out_valid, IDLE next cycle.
REQ-036 DATA_W=8: SRL a=80h shamt=7 -> result=01h; MUL 0FFh*0FFh -> result=01h, result_hi=0FEh after 9 cycles.
